// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order integer pipeline.
// A shift-register scoreboard tracks post-decode stages and drives stall, forward selects and halt.
module pipe_hazard_ctrl #(
  parameter int REG_W          = 4,
  parameter int NUM_STAGES     = 3,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int FLUSH_DEPTH    = 0,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_W-1:0]      id_rs,
  input  logic [REG_W-1:0]      id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_W-1:0]      id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_halt,
  input  logic                  id_src_in_id,
  input  logic                  flush,
  output logic                  stall,
  output logic [NUM_STAGES-1:0] ex_fwd_a,
  output logic [NUM_STAGES-1:0] ex_fwd_b,
  output logic [NUM_STAGES-1:0] id_fwd_a,
  output logic [NUM_STAGES-1:0] id_fwd_b,
  output logic                  halt_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int NS = NUM_STAGES;

  logic [NS-1:0]            sb_valid;
  logic [NS-1:0]            sb_reg_write;
  logic [NS-1:0]            sb_is_load;
  logic [NS-1:0]            sb_is_halt;
  logic [NS-1:0][REG_W-1:0] sb_rd;

  // Only the EX entry ever consumes its sources, so older stages do not carry them.
  logic [REG_W-1:0]         ex_rs;
  logic [REG_W-1:0]         ex_rt;
  logic                     ex_use_rs;
  logic                     ex_use_rt;

  logic [NS-1:0] producer;
  logic [NS-1:0] id_match_a;
  logic [NS-1:0] id_match_b;
  logic [NS-1:0] ex_match_a;
  logic [NS-1:0] ex_match_b;
  logic [NS-1:0] hazard_ex;
  logic [NS-1:0] hazard_id;
  logic [NS-1:0] id_pick_a;
  logic [NS-1:0] id_pick_b;
  logic          stall_raw;
  logic          issue;

  function automatic logic [NS-1:0] lowest_set(input logic [NS-1:0] m);
    return m & (~m + NS'(1));
  endfunction

  always_comb begin
    producer   = '0;
    id_match_a = '0;
    id_match_b = '0;
    ex_match_a = '0;
    ex_match_b = '0;
    hazard_ex  = '0;
    hazard_id  = '0;
    for (int j = 0; j < NS; j++) begin
      producer[j]   = sb_valid[j] & sb_reg_write[j] & (sb_rd[j] != '0);
      id_match_a[j] = producer[j] & id_use_rs & (sb_rd[j] == id_rs);
      id_match_b[j] = producer[j] & id_use_rt & (sb_rd[j] == id_rt);
      hazard_ex[j]  = sb_is_load[j] && (j + 1 < LOAD_FWD_STAGE);
      hazard_id[j]  = sb_is_load[j] ? (j < LOAD_FWD_STAGE) : (j < 1);
    end
    for (int j = 1; j < NS; j++) begin
      ex_match_a[j] = producer[j] & sb_valid[0] & ex_use_rs & (sb_rd[j] == ex_rs);
      ex_match_b[j] = producer[j] & sb_valid[0] & ex_use_rt & (sb_rd[j] == ex_rt);
    end
    stall_raw = id_src_in_id ? |((id_match_a | id_match_b) & hazard_id)
                             : |((id_match_a | id_match_b) & hazard_ex);
    // Youngest match over all stages; if it is not ready the select stays 0 and stall covers it.
    id_pick_a = lowest_set(id_match_a);
    id_pick_b = lowest_set(id_match_b);
  end

  assign stall = stall_raw & id_valid & ~flush & ~halt_out & ~rst;
  assign issue = id_valid & ~stall & ~flush & ~halt_out;

  assign ex_fwd_a = rst ? '0 : lowest_set(ex_match_a);
  assign ex_fwd_b = rst ? '0 : lowest_set(ex_match_b);
  assign id_fwd_a = (id_src_in_id && !rst && ((id_pick_a & hazard_id) == '0)) ? id_pick_a : '0;
  assign id_fwd_b = (id_src_in_id && !rst && ((id_pick_b & hazard_id) == '0)) ? id_pick_b : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid     <= '0;
      sb_reg_write <= '0;
      sb_is_load   <= '0;
      sb_is_halt   <= '0;
      sb_rd        <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_use_rs    <= 1'b0;
      ex_use_rt    <= 1'b0;
      halt_out     <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      sb_valid[0]     <= issue;
      sb_reg_write[0] <= id_reg_write;
      sb_is_load[0]   <= id_is_load;
      sb_is_halt[0]   <= id_is_halt;
      sb_rd[0]        <= id_rd;
      ex_rs           <= id_rs;
      ex_rt           <= id_rt;
      ex_use_rs       <= id_use_rs;
      ex_use_rt       <= id_use_rt;
      for (int j = 1; j < NS; j++) begin
        if (flush && j <= FLUSH_DEPTH) sb_valid[j] <= 1'b0;
        else                           sb_valid[j] <= sb_valid[j-1];
        sb_reg_write[j] <= sb_reg_write[j-1];
        sb_is_load[j]   <= sb_is_load[j-1];
        sb_is_halt[j]   <= sb_is_halt[j-1];
        sb_rd[j]        <= sb_rd[j-1];
      end
      if (sb_valid[NS-1] && sb_is_halt[NS-1]) halt_out <= 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl at default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [3:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       id_is_halt;
  logic       id_src_in_id;
  logic       flush;
  logic       stall;
  logic [2:0] ex_fwd_a;
  logic [2:0] ex_fwd_b;
  logic [2:0] id_fwd_a;
  logic [2:0] id_fwd_b;
  logic       halt_out;
  logic [15:0] stall_cnt;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_halt(id_is_halt),
    .id_src_in_id(id_src_in_id), .flush(flush), .stall(stall),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
    .halt_out(halt_out), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic [3:0] rd,
                       input logic rw, input logic ld, input logic hlt, input logic sid);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_is_load = ld; id_is_halt = hlt; id_src_in_id = sid;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    drive(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [3:0] rd, input logic [3:0] rs);
    drive(1'b1, rs, 4'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic br(input logic [3:0] rs, input logic [3:0] rt);
    drive(1'b1, rs, rt, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nop();
    alu(4'd3, 4'd3, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (ex_fwd_a !== 3'b000 || ex_fwd_b !== 3'b000) begin errors++; $display("FAIL reset_ex_fwd: got %b/%b want 000/000", ex_fwd_a, ex_fwd_b); end
    checks++; if (id_fwd_a !== 3'b000 || id_fwd_b !== 3'b000) begin errors++; $display("FAIL reset_id_fwd: got %b/%b want 000/000", id_fwd_a, id_fwd_b); end
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt_out); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    rst = 1'b0;
    nop();
  endtask

  task automatic test_alu_forward();
    drain();
    alu(4'd3, 4'd1, 4'd2); #1;
    tick(); alu(4'd6, 4'd3, 4'd1); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %b want 0", stall); end
    tick(); alu(4'd7, 4'd3, 4'd1); #1;
    checks++; if (ex_fwd_a !== 3'b010) begin errors++; $display("FAIL alu_fwd_stage1: got %b want 010", ex_fwd_a); end
    checks++; if (id_fwd_a !== 3'b000) begin errors++; $display("FAIL alu_no_id_fwd: got %b want 000", id_fwd_a); end
    tick(); nop(); #1;
    checks++; if (ex_fwd_a !== 3'b100) begin errors++; $display("FAIL alu_fwd_stage2: got %b want 100", ex_fwd_a); end
    checks++; if (ex_fwd_b !== 3'b000) begin errors++; $display("FAIL alu_fwd_b_none: got %b want 000", ex_fwd_b); end
  endtask

  task automatic test_load_use();
    drain();
    load(4'd5, 4'd1); #1;
    tick(); alu(4'd8, 4'd5, 4'd2); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", stall); end
    tick(); #1;
    exp_cnt++;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b want 0", stall); end
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    tick(); nop(); #1;
    checks++; if (ex_fwd_a !== 3'b100) begin errors++; $display("FAIL load_use_fwd: got %b want 100", ex_fwd_a); end
    drain();
    load(4'd5, 4'd1); #1;
    tick(); drive(1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_src_stall: got %b want 0", stall); end
  endtask

  task automatic test_youngest();
    drain();
    alu(4'd2, 4'd1, 4'd1); #1;
    tick(); alu(4'd2, 4'd3, 4'd3); #1;
    tick(); alu(4'd9, 4'd1, 4'd2); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL youngest_stall: got %b want 0", stall); end
    tick(); nop(); #1;
    checks++; if (ex_fwd_b !== 3'b010) begin errors++; $display("FAIL youngest_fwd_b: got %b want 010", ex_fwd_b); end
    checks++; if (ex_fwd_a !== 3'b000) begin errors++; $display("FAIL youngest_fwd_a: got %b want 000", ex_fwd_a); end
  endtask

  task automatic test_r0();
    drain();
    alu(4'd0, 4'd1, 4'd2); #1;
    tick(); alu(4'd9, 4'd0, 4'd0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", stall); end
    tick(); nop(); #1;
    checks++; if (ex_fwd_a !== 3'b000 || ex_fwd_b !== 3'b000) begin errors++; $display("FAIL r0_fwd: got %b/%b want 000/000", ex_fwd_a, ex_fwd_b); end
    load(4'd0, 4'd1); #1;
    tick(); br(4'd0, 4'd0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_load_br_stall: got %b want 0", stall); end
  endtask

  task automatic test_id_consumer();
    drain();
    alu(4'd4, 4'd1, 4'd2); #1;
    tick(); br(4'd4, 4'd1); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %b want 1", stall); end
    checks++; if (id_fwd_a !== 3'b000) begin errors++; $display("FAIL br_no_skip: got %b want 000", id_fwd_a); end
    tick(); #1;
    exp_cnt++;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_release: got %b want 0", stall); end
    checks++; if (id_fwd_a !== 3'b010) begin errors++; $display("FAIL br_id_fwd: got %b want 010", id_fwd_a); end
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL br_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    drain();
    load(4'd5, 4'd1); #1;
    tick(); nop(); #1;
    tick(); br(4'd5, 4'd0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_load_stall: got %b want 1", stall); end
    tick(); #1;
    exp_cnt++;
    checks++; if (stall !== 1'b0 || id_fwd_a !== 3'b100) begin errors++; $display("FAIL br_load_fwd: got stall=%b fwd=%b want 0/100", stall, id_fwd_a); end
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL br_load_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    drain();
    alu(4'd7, 4'd1, 4'd1); flush = 1'b1; #1;
    tick(); flush = 1'b0; alu(4'd9, 4'd7, 4'd7); #1;
    tick(); nop(); #1;
    checks++; if (ex_fwd_a !== 3'b000) begin errors++; $display("FAIL flush_killed: got %b want 000", ex_fwd_a); end
    load(4'd5, 4'd1); #1;
    tick(); alu(4'd8, 4'd5, 4'd5); flush = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_mask: got %b want 0", stall); end
    tick(); nop(); #1;
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_halt();
    drain();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    tick(); nop(); #1;
    tick(); #1;
    tick(); #1;
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", halt_out); end
    tick(); #1;
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halt_out); end
    alu(4'd6, 4'd1, 4'd1); #1;
    tick(); alu(4'd9, 4'd6, 4'd6); #1;
    tick(); nop(); #1;
    checks++; if (ex_fwd_a !== 3'b000) begin errors++; $display("FAIL halt_ignores_issue: got %b want 000", ex_fwd_a); end
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", halt_out); end
    rst = 1'b1; #1;
    exp_cnt = 0;
    checks++; if (halt_out !== 1'b0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL halt_async_rst: got halt=%b cnt=%0d want 0/0", halt_out, stall_cnt); end
    tick(); rst = 1'b0; nop();
  endtask

  task automatic test_reset_midflight();
    drain();
    alu(4'd3, 4'd1, 4'd1); #1;
    tick(); alu(4'd9, 4'd3, 4'd3); #1;
    tick(); load(4'd5, 4'd3); #1;
    tick(); br(4'd5, 4'd9); #1;
    checks++; if (stall !== 1'b1 || ex_fwd_a !== 3'b100 || id_fwd_b !== 3'b010) begin errors++; $display("FAIL mid_pre1: got stall=%b exa=%b idb=%b want 1/100/010", stall, ex_fwd_a, id_fwd_b); end
    tick(); #1;
    exp_cnt++;
    checks++; if (stall !== 1'b1 || id_fwd_b !== 3'b100 || stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mid_pre2: got stall=%b idb=%b cnt=%0d want 1/100/%0d", stall, id_fwd_b, stall_cnt, exp_cnt); end
    rst = 1'b1; #1;
    exp_cnt = 0;
    checks++; if (stall !== 1'b0 || stall_cnt !== 16'd0 || halt_out !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got stall=%b cnt=%0d halt=%b want 0/0/0", stall, stall_cnt, halt_out); end
    checks++; if (ex_fwd_a !== 3'b000 || ex_fwd_b !== 3'b000 || id_fwd_a !== 3'b000 || id_fwd_b !== 3'b000) begin errors++; $display("FAIL mid_rst_fwd: got %b %b %b %b want all 000", ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b); end
    tick(); rst = 1'b0; br(4'd5, 4'd9); #1;
    checks++; if (stall !== 1'b0 || id_fwd_b !== 3'b000) begin errors++; $display("FAIL mid_discarded: got stall=%b idb=%b want 0/000", stall, id_fwd_b); end
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_r0();
    test_id_consumer();
    test_flush();
    test_halt();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order integer pipeline. It replaces the fixed 5-stage forwarding and stall logic.
- Keeps a shift-register scoreboard of in-flight instructions, one entry per post-decode stage (stage 0 = EX, stage NUM_STAGES-1 = last stage before register-file write).
- Generates the ID stall, one-hot forward selects for EX and ID operands, a sticky halt, and a stall-cycle counter.

Parameters:
- REG_W, 4: register address width.
- NUM_STAGES, 3: tracked post-decode stages. Legal range is 2..8.
- LOAD_FWD_STAGE, 2: first stage index at which load data can be forwarded. Legal range is 1..NUM_STAGES-1.
- FLUSH_DEPTH, 0: number of younger tracked stages (0..FLUSH_DEPTH-1) killed on flush.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  source A.
- id_rt  in  REG_W  source B.
- id_use_rs  in  1  source A is read.
- id_use_rt  in  1  source B is read.
- id_rd  in  REG_W  destination.
- id_reg_write  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- id_is_halt  in  1  instruction is HLT.
- id_src_in_id  in  1  operands are consumed in ID (BR).
- flush  in  1  kill the ID instruction and stages 0..FLUSH_DEPTH-1.
- stall  out  1  hold IF/ID and PC; insert bubble.
- ex_fwd_a  out  NUM_STAGES  one-hot forward source for the stage-0 operand A; 0 = use register value.
- ex_fwd_b  out  NUM_STAGES  one-hot forward source for the stage-0 operand B; 0 = use register value.
- id_fwd_a  out  NUM_STAGES  one-hot forward source for the ID operand A.
- id_fwd_b  out  NUM_STAGES  one-hot forward source for the ID operand B.
- halt_out  out  1  sticky halt.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Entry fields: {valid, rd, reg_write, is_load, is_halt, rs, rt, use_rs, use_rt}.
- Every clock, stage j+1 takes stage j. Stage NUM_STAGES-1 retires.
- Stage 0 loads the ID fields when id_valid & ~stall & ~flush & ~halt_out. Otherwise stage 0 loads a bubble (valid=0).
- Flush: stages 0..FLUSH_DEPTH-1 load a bubble instead of shifting. Their contents are discarded and stage FLUSH_DEPTH receives a bubble.
- Producer match at stage j (j >= 0) requires all of: valid, reg_write, rd != 0, rd equal to the consumer's source, and the consumer's use bit set. R0 never matches.
- Ready stage: a producer is ready at stage j if j >= R, where R = LOAD_FWD_STAGE for loads and R = 1 otherwise.
- Stall for EX consumers (id_src_in_id=0): stall=1 if any matching producer at stage j has j+1 < R.
- Stall for ID consumers (id_src_in_id=1): stall=1 if any matching producer at stage j has j < R.
- Stall is combinational and is forced to 0 when flush=1, halt_out=1, or id_valid=0.
- ex_fwd_a/b: compare the stage-0 entry's rs/rt against stages 1..NUM_STAGES-1. Select the youngest matching stage (lowest index). Bit 0 is always 0. Output is all-zero if stage 0 is invalid or there is no match.
- id_fwd_a/b: same selection against stages 1..NUM_STAGES-1 for id_rs/id_rt. Driven only when id_src_in_id=1, otherwise 0.
- Priority: a non-ready younger match causes stall; the select never skips it for an older stage.
- halt_out: set on the clock edge after a valid halt entry reaches stage NUM_STAGES-1. It stays 1 until rst.
- stall_cnt: +1 per cycle with stall=1; saturates at all-ones.
- Reset state (async): all stages invalid, halt_out=0, stall_cnt=0. All selects are 0 and stall=0 while rst=1.
- Reset mid-operation discards all in-flight entries immediately.

Test Plan:
All scenarios use default parameters.
1. ADD r3 issued at cycle t, SUB reading r3 at t+1 → stall=0. At t+2, ex_fwd_a=3'b010. A consumer two slots behind gets ex_fwd_a=3'b100.
2. LW r5 followed immediately by ADD r5 → stall=1 for exactly one cycle, then stall_cnt=1. ADD enters stage 0 with ex_fwd_a=3'b100.
3. Writers to r2 occupy stages 1 and 2, consumer of r2 in stage 0 → ex_fwd_b=3'b010 (youngest wins).
4. ADD r0 followed by a consumer of r0 → no stall, all forward selects 0.
5. ADD r4 in stage 0 with BR reading r4 in ID → stall=1 for one cycle, then id_fwd_a=3'b010, stall=0.
6. HLT issued, then rst asserted mid-flight at a second run → first run: halt_out=1 three cycles after issue and further issues are ignored. On the second run's rst: all outputs 0 within the same cycle.
